mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline memory stage directly downstream of the execute stage.
- Contains the EX/MEM register and a request/acknowledge data-memory handshake FSM.
- Handles byte-lane steering for word, halfword and byte stores, and extension of loaded data.
- Drives a registered MEM/WB result toward write-back; raises stall_out to freeze upstream stages while a memory access is outstanding.

Parameters:
- AW, 32, width of dmem_addr.
- DW, 32, datapath width; fixed at 32, other values are unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall_in  in  1  upstream bubble request; loads a zeroed (NOP) entry into EX/MEM.
- dInst  in  32  instruction from execute.
- dMemWr  in  1  store.
- dMemToReg  in  1  load.
- dRegWr  in  1  register write enable.
- dJal  in  1  write Delayslot2 instead of ALU or load result.
- dLoadext  in  1  1 = sign-extend load, 0 = zero-extend.
- dDsize  in  2  00 word, 01 halfword, 10 byte, 11 treated as word.
- dFPoint  in  2  passed through.
- dALUout  in  32  effective address or ALU result.
- dBusB  in  32  store data.
- dRw  in  5  destination register.
- dDelayslot2  in  32  link value.
- dmem_req  out  1  access request.
- dmem_we  out  1  write.
- dmem_addr  out  AW  word-aligned address {ALUout[31:2],2'b00}.
- dmem_be  out  4  byte enables; bit3 = bits 31:24.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read word, valid with ack.
- dmem_ack  in  1  completes the access.
- stall_out  out  1  stage busy; upstream must hold.
- wbInst  out  32  registered.
- wbRegWr  out  1  registered.
- wbRw  out  5  registered.
- wbData  out  32  registered.
- wbFPoint  out  2  registered.
- misalign  out  1  only with MISALIGN_TRAP_EN; tied 0 otherwise.

Behaviour:
- Reset (rst_n=0 at edge): all EX/MEM fields 0, FSM to IDLE, all wb* outputs 0, dmem_req/we/be 0, stall_out 0. Reset mid-access abandons the access; a late ack is ignored.
- mem_op = qMemWr | qMemToReg.
- EX/MEM load rules:
  - stall_out=1: hold.
  - else stall_in=1: load all zeros.
  - else: load d*.
- FSM states:
  - IDLE: if mem_op, assert dmem_req combinationally with the latched address, we, be and wdata.
    - Ack in the same cycle: completes, no stall.
    - No ack: go to WAIT.
  - WAIT: hold dmem_req and all dmem_* stable until ack. On ack, return to IDLE.
- stall_out = mem_op & ~dmem_ack, in both IDLE and WAIT.
- MEM/WB register:
  - Updates at an edge where stall_out=0.
  - When stall_out=1 it loads wbRegWr=0 (bubble), so the held instruction is written back exactly once.
  - Latency: non-memory op, 1 cycle EX/MEM to wb*. Memory op with ack after n wait cycles, 1+n cycles.
- wbData priority:
  1. qJal: Delayslot2.
  2. qMemToReg: extended load.
  3. Otherwise: ALUout.
- Byte lanes are big-endian; byte offset a = ALUout[1:0].
  - Word: be=1111.
  - Halfword: be=1100 if a[1]=0, else 0011; wdata={BusB[15:0],BusB[15:0]}.
  - Byte: be = 1000>>a; wdata = BusB[7:0] replicated 4x.
  - Loads select the same lane from rdata, then sign- or zero-extend to 32 bits.
- Misaligned access without the feature: low address bits beyond the access size are ignored. Halfword uses a[1] only; word ignores a.
- Non-memory ops: dmem_req=0, be=0000.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access is a halfword with a[0]=1, or a word with a!=0.
  - Suppresses dmem_req, so no stall.
  - Forces wbRegWr=0.
  - Drives misalign=1 registered alongside wb* for one cycle.
- Undefined: misalign port tied 0; ignore-low-bits behaviour applies.

Test Plan:
- Reset held 2 cycles with dmem_ack=1 -> all wb* 0, dmem_req 0, stall_out 0.
- ADD, ALUout=0x00000010, RegWr=1, Rw=5 -> next edge wbData=0x10, wbRw=5, wbRegWr=1, no dmem_req.
- Store byte to addr 0x103, BusB=0xAB, ack same cycle -> dmem_addr=0x100, be=0001, wdata=0xABABABAB, we=1, stall_out 0.
- Load halfword to 0x202, Loadext=1, ack after 3 cycles, rdata=0x1234F00D:
  - stall_out high 3 cycles; EX/MEM held.
  - wbData=0xFFFFF00D written once; wbRegWr 0 during the wait cycles.
- Same load with Loadext=0 -> wbData=0x0000F00D. Byte load to 0x200, rdata=0x80xxxxxx, Loadext=1 -> 0xFFFFFF80.
- stall_in=1 with Jal and Delayslot2=0x44 presented -> bubble, wbRegWr=0. Next cycle without stall -> wbData=0x44. rst_n low during WAIT -> IDLE, req drops.

Source files
------------

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, data-memory req/ack FSM, byte-lane steering and load extension.
// Optional build macro MISALIGN_TRAP_EN turns misaligned halfword/word accesses into traps instead of memory requests.
module mem_stage #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_in,
    input  logic [31:0]   dInst,
    input  logic          dMemWr,
    input  logic          dMemToReg,
    input  logic          dRegWr,
    input  logic          dJal,
    input  logic          dLoadext,
    input  logic [1:0]    dDsize,
    input  logic [1:0]    dFPoint,
    input  logic [DW-1:0] dALUout,
    input  logic [DW-1:0] dBusB,
    input  logic [4:0]    dRw,
    input  logic [DW-1:0] dDelayslot2,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          stall_out,
    output logic [31:0]   wbInst,
    output logic          wbRegWr,
    output logic [4:0]    wbRw,
    output logic [DW-1:0] wbData,
    output logic [1:0]    wbFPoint,
    output logic          misalign
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t        state_r, state_next_s;
    logic [31:0]   q_inst_r;
    logic          q_memwr_r, q_memtoreg_r, q_regwr_r, q_jal_r, q_loadext_r;
    logic [1:0]    q_dsize_r, q_fpoint_r;
    logic [DW-1:0] q_aluout_r, q_busb_r, q_delayslot2_r;
    logic [4:0]    q_rw_r;
    logic          mem_op_s, mis_s, access_s, stall_s;
    logic [DW-1:0] result_s;

    // Big-endian byte enables: bit 3 is the most significant byte lane.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b01:   lane_be = a[1] ? 4'b0011 : 4'b1100;
            2'b10:   lane_be = 4'b1000 >> a;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [DW-1:0] store_lanes(input logic [1:0] size, input logic [DW-1:0] busb);
        case (size)
            2'b01:   store_lanes = {2{busb[15:0]}};
            2'b10:   store_lanes = {4{busb[7:0]}};
            default: store_lanes = busb;
        endcase
    endfunction

    function automatic logic [DW-1:0] load_extend(input logic [1:0] size, input logic [1:0] a,
                                                  input logic ext, input logic [DW-1:0] rdata);
        logic [15:0] half;
        logic [7:0]  byte_v;
        half = a[1] ? rdata[15:0] : rdata[31:16];
        case (a)
            2'b00:   byte_v = rdata[31:24];
            2'b01:   byte_v = rdata[23:16];
            2'b10:   byte_v = rdata[15:8];
            default: byte_v = rdata[7:0];
        endcase
        case (size)
            2'b01:   load_extend = {{16{ext & half[15]}}, half};
            2'b10:   load_extend = {{24{ext & byte_v[7]}}, byte_v};
            default: load_extend = rdata;
        endcase
    endfunction

    assign mem_op_s = q_memwr_r | q_memtoreg_r;
`ifdef MISALIGN_TRAP_EN
    assign mis_s = mem_op_s & (((q_dsize_r == 2'b01) & q_aluout_r[0]) |
                               (((q_dsize_r == 2'b00) | (q_dsize_r == 2'b11)) & (q_aluout_r[1:0] != 2'b00)));
`else
    assign mis_s = 1'b0;
`endif
    assign access_s  = mem_op_s & ~mis_s;
    assign stall_s   = access_s & ~dmem_ack;
    assign stall_out = stall_s;

    // Request FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and memory-port drive; EX/MEM is held while waiting, so dmem_* stay stable.
    always_comb begin
        state_next_s = state_r;
        dmem_req     = 1'b0;
        case (state_r)
            IDLE: begin
                dmem_req = access_s;
                if (access_s && !dmem_ack) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
                dmem_req     = 1'b0;
            end
        endcase
    end

    assign dmem_we    = dmem_req & q_memwr_r;
    assign dmem_be    = dmem_req ? lane_be(q_dsize_r, q_aluout_r[1:0]) : 4'b0000;
    assign dmem_addr  = {q_aluout_r[AW-1:2], 2'b00};
    assign dmem_wdata = store_lanes(q_dsize_r, q_busb_r);

    // Write-back result selection: link value beats load data beats ALU result.
    always_comb begin
        result_s = q_aluout_r;
        if (q_jal_r) begin
            result_s = q_delayslot2_r;
        end else if (q_memtoreg_r) begin
            result_s = load_extend(q_dsize_r, q_aluout_r[1:0], q_loadext_r, dmem_rdata);
        end else begin
            result_s = q_aluout_r;
        end
    end

    // EX/MEM register: hold while busy, bubble on upstream stall, else capture execute outputs.
    always_ff @(posedge clk) begin
        if (!rst_n || (!stall_s && stall_in)) begin
            q_inst_r       <= 32'd0;
            q_memwr_r      <= 1'b0;
            q_memtoreg_r   <= 1'b0;
            q_regwr_r      <= 1'b0;
            q_jal_r        <= 1'b0;
            q_loadext_r    <= 1'b0;
            q_dsize_r      <= 2'b00;
            q_fpoint_r     <= 2'b00;
            q_aluout_r     <= '0;
            q_busb_r       <= '0;
            q_rw_r         <= 5'd0;
            q_delayslot2_r <= '0;
        end else if (!stall_s) begin
            q_inst_r       <= dInst;
            q_memwr_r      <= dMemWr;
            q_memtoreg_r   <= dMemToReg;
            q_regwr_r      <= dRegWr;
            q_jal_r        <= dJal;
            q_loadext_r    <= dLoadext;
            q_dsize_r      <= dDsize;
            q_fpoint_r     <= dFPoint;
            q_aluout_r     <= dALUout;
            q_busb_r       <= dBusB;
            q_rw_r         <= dRw;
            q_delayslot2_r <= dDelayslot2;
        end
    end

    // MEM/WB register: a stall cycle writes a bubble so the held access retires exactly once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbInst   <= 32'd0;
            wbRegWr  <= 1'b0;
            wbRw     <= 5'd0;
            wbData   <= '0;
            wbFPoint <= 2'b00;
        end else if (stall_s) begin
            wbRegWr  <= 1'b0;
        end else begin
            wbInst   <= q_inst_r;
            wbRegWr  <= q_regwr_r & ~mis_s;
            wbRw     <= q_rw_r;
            wbData   <= result_s;
            wbFPoint <= q_fpoint_r;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_r;

    // Trap flag travels with the write-back fields for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else if (stall_s) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= mis_s;
        end
    end
    assign misalign = misalign_r;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written corner sequences and a randomized
// run scored against a transaction-level reference model.
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic        memwr, memtoreg, regwr, jal, loadext;
        logic [1:0]  dsize, fpoint;
        logic [31:0] alu, busb;
        logic [4:0]  rw;
        logic [31:0] ds2;
    } instr_t;

    typedef struct {
        instr_t      ins;
        int          delay;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] addr, wdata, wb;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall_in, dmem_req, dmem_we, dmem_ack, stall_out, wbRegWr, misalign;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wbInst, wbData;
    logic [3:0]  dmem_be;
    logic [4:0]  wbRw;
    logic [1:0]  wbFPoint;
    instr_t      cur;

    mem_stage #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
        .dInst(cur.inst), .dMemWr(cur.memwr), .dMemToReg(cur.memtoreg), .dRegWr(cur.regwr),
        .dJal(cur.jal), .dLoadext(cur.loadext), .dDsize(cur.dsize), .dFPoint(cur.fpoint),
        .dALUout(cur.alu), .dBusB(cur.busb), .dRw(cur.rw), .dDelayslot2(cur.ds2),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_out(stall_out), .wbInst(wbInst), .wbRegWr(wbRegWr), .wbRw(wbRw),
        .wbData(wbData), .wbFPoint(wbFPoint), .misalign(misalign)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: the instruction sitting in the stage and the expected write-back view.
    instr_t      p;
    logic        known = 1'b0;
    int          ack_wait = 0;
    int          next_delay = 0;
    logic        use_fix = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] fix_rdata = 32'd0;
    logic [31:0] e_inst = 32'd0, e_data = 32'd0;
    logic        e_regwr = 1'b0;
    logic [4:0]  e_rw = 5'd0;
    logic [1:0]  e_fp = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] dsize);
        if (dsize == 2'b01) return 2;
        if (dsize == 2'b10) return 1;
        return 4;
    endfunction

    function automatic int first_byte(input logic [1:0] dsize, input logic [31:0] addr);
        int n = nbytes(dsize);
        if (n == 4) return 0;
        if (n == 2) return (addr % 4 >= 2) ? 2 : 0;
        return addr % 4;
    endfunction

    // Byte i counts from the most significant end of the word.
    function automatic logic [3:0] m_be(input logic [1:0] dsize, input logic [31:0] addr);
        int n = nbytes(dsize);
        int o = first_byte(dsize, addr);
        logic [3:0] be = 4'b0000;
        for (int i = 0; i < 4; i++) if (i >= o && i < o + n) be[3-i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] dsize, input logic [31:0] busb);
        int n = nbytes(dsize);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < 4; i++) w = (w << 8) | ((busb >> (8 * (n - 1 - (i % n)))) & 32'hFF);
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] dsize, input logic [31:0] addr,
                                           input logic ext, input logic [31:0] rdata);
        int n = nbytes(dsize);
        int o = first_byte(dsize, addr);
        logic [31:0] mask = (n == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * n)) - 32'd1);
        logic [31:0] v = (rdata >> (8 * (4 - o - n))) & mask;
        if (ext && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // One clock: drive memory response, check the combinational side mid-cycle, advance the model, check wb.
    task automatic cycle();
        logic mem;
        mem = known && (p.memwr || p.memtoreg);
        dmem_rdata = use_fix ? fix_rdata : $urandom;
        if (!rst_n || force_ack) dmem_ack = 1'b1;
        else if (mem) dmem_ack = (ack_wait == 0);
        else dmem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (known && rst_n) begin
            chk("stall_out", {31'd0, stall_out}, {31'd0, mem & ~dmem_ack});
            chk("dmem_req", {31'd0, dmem_req}, {31'd0, mem});
            chk("misalign", {31'd0, misalign}, 32'd0);
            if (mem) begin
                chk("dmem_addr", dmem_addr, p.alu & 32'hFFFFFFFC);
                chk("dmem_be", {28'd0, dmem_be}, {28'd0, m_be(p.dsize, p.alu)});
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, p.memwr});
                if (p.memwr) chk("dmem_wdata", dmem_wdata, m_wdata(p.dsize, p.busb));
            end else begin
                chk("dmem_be_idle", {28'd0, dmem_be}, 32'd0);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            p = '0; known = 1'b1; ack_wait = 0;
            e_inst = 32'd0; e_data = 32'd0; e_regwr = 1'b0; e_rw = 5'd0; e_fp = 2'b00;
        end else if (mem && !dmem_ack) begin
            e_regwr = 1'b0;
            ack_wait--;
        end else begin
            e_inst = p.inst; e_regwr = p.regwr; e_rw = p.rw; e_fp = p.fpoint;
            if (p.jal) e_data = p.ds2;
            else if (p.memtoreg) e_data = m_load(p.dsize, p.alu, p.loadext, dmem_rdata);
            else e_data = p.alu;
            p = stall_in ? '0 : cur;
            ack_wait = next_delay;
        end
        #1;
        if (known) begin
            chk("wbRegWr", {31'd0, wbRegWr}, {31'd0, e_regwr});
            chk("wbData", wbData, e_data);
            chk("wbRw", {27'd0, wbRw}, {27'd0, e_rw});
            chk("wbInst", wbInst, e_inst);
            chk("wbFPoint", {30'd0, wbFPoint}, {30'd0, e_fp});
        end
    endtask

    function automatic instr_t mk(input logic wr, input logic ld, input logic rw_en, input logic jal,
                                  input logic ext, input logic [1:0] sz, input logic [31:0] alu,
                                  input logic [31:0] busb, input logic [4:0] rd, input logic [31:0] ds2);
        instr_t t;
        t.inst = 32'hC0DE0000 | alu[15:0]; t.memwr = wr; t.memtoreg = ld; t.regwr = rw_en; t.jal = jal;
        t.loadext = ext; t.dsize = sz; t.fpoint = 2'b10; t.alu = alu; t.busb = busb; t.rw = rd; t.ds2 = ds2;
        return t;
    endfunction

    vec_t vecs[11];

    initial begin
        rst_n = 1'b0; stall_in = 1'b0; cur = '0; dmem_ack = 1'b1; dmem_rdata = 32'd0; p = '0;

        vecs[0]  = '{mk(0,0,1,0,0,2'b00,32'h10,32'h0,5'd5,32'h0), 0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h10};
        vecs[1]  = '{mk(1,0,0,0,0,2'b10,32'h103,32'h123456AB,5'd0,32'h0), 0, 32'h0, 4'b0001, 32'h100, 32'hABABABAB, 32'h103};
        vecs[2]  = '{mk(0,1,1,0,1,2'b01,32'h202,32'h0,5'd7,32'h0), 3, 32'h1234F00D, 4'b0011, 32'h200, 32'h0, 32'hFFFFF00D};
        vecs[3]  = '{mk(0,1,1,0,0,2'b01,32'h202,32'h0,5'd7,32'h0), 3, 32'h1234F00D, 4'b0011, 32'h200, 32'h0, 32'h0000F00D};
        vecs[4]  = '{mk(0,1,1,0,1,2'b10,32'h200,32'h0,5'd8,32'h0), 1, 32'h80ABCDEF, 4'b1000, 32'h200, 32'h0, 32'hFFFFFF80};
        vecs[5]  = '{mk(1,0,0,0,0,2'b01,32'h200,32'hCAFEBEEF,5'd0,32'h0), 1, 32'h0, 4'b1100, 32'h200, 32'hBEEFBEEF, 32'h200};
        vecs[6]  = '{mk(1,0,0,0,0,2'b00,32'h307,32'h01020304,5'd0,32'h0), 2, 32'h0, 4'b1111, 32'h304, 32'h01020304, 32'h307};
        vecs[7]  = '{mk(0,1,1,0,1,2'b00,32'h40,32'h0,5'd9,32'h0), 0, 32'h89ABCDEF, 4'b1111, 32'h40, 32'h0, 32'h89ABCDEF};
        vecs[8]  = '{mk(0,0,1,1,0,2'b00,32'h99,32'h0,5'd31,32'h44), 0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h44};
        vecs[9]  = '{mk(0,1,1,0,0,2'b11,32'h12,32'h0,5'd3,32'h0), 0, 32'hDEADBEEF, 4'b1111, 32'h10, 32'h0, 32'hDEADBEEF};
        vecs[10] = '{mk(0,1,1,0,0,2'b10,32'h203,32'h0,5'd4,32'h0), 2, 32'h123456F7, 4'b0001, 32'h200, 32'h0, 32'h000000F7};

        cycle();
        cycle();
        chk("reset_wbRegWr", {31'd0, wbRegWr}, 32'd0);
        chk("reset_wbData", wbData, 32'd0);
        chk("reset_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("reset_stall_out", {31'd0, stall_out}, 32'd0);
        rst_n = 1'b1;
        cycle();

        foreach (vecs[v]) begin
            cur = vecs[v].ins; stall_in = 1'b0; next_delay = vecs[v].delay;
            use_fix = 1'b1; fix_rdata = vecs[v].rdata;
            cycle();
            if (vecs[v].ins.memwr || vecs[v].ins.memtoreg) begin
                chk("vec_req", {31'd0, dmem_req}, 32'd1);
                chk("vec_addr", dmem_addr, vecs[v].addr);
                chk("vec_be", {28'd0, dmem_be}, {28'd0, vecs[v].be});
                if (vecs[v].ins.memwr) chk("vec_wdata", dmem_wdata, vecs[v].wdata);
            end else begin
                chk("vec_noreq", {31'd0, dmem_req}, 32'd0);
            end
            cur = '0;
            for (int k = 0; k <= vecs[v].delay; k++) begin
                if (k > 0) chk("vec_wait_regwr", {31'd0, wbRegWr}, 32'd0);
                cycle();
            end
            chk("vec_wbData", wbData, vecs[v].wb);
            chk("vec_wbRegWr", {31'd0, wbRegWr}, {31'd0, vecs[v].ins.regwr});
            use_fix = 1'b0;
        end

        // Upstream bubble with a JAL presented, then the same JAL accepted.
        cur = mk(0,0,1,1,0,2'b00,32'h77,32'h0,5'd9,32'h44); stall_in = 1'b1; next_delay = 0;
        cycle();
        stall_in = 1'b0;
        cycle();
        chk("bubble_wbRegWr", {31'd0, wbRegWr}, 32'd0);
        cur = '0;
        cycle();
        chk("jal_wbData", wbData, 32'h44);
        chk("jal_wbRegWr", {31'd0, wbRegWr}, 32'd1);

        // Reset while waiting for an ack, then a late ack must be ignored.
        cur = mk(0,1,1,0,1,2'b00,32'h80,32'h0,5'd2,32'h0); next_delay = 10;
        cycle();
        cur = '0;
        cycle();
        cycle();
        chk("wait_stall", {31'd0, stall_out}, 32'd1);
        rst_n = 1'b0;
        cycle();
        chk("rst_wait_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wait_stall", {31'd0, stall_out}, 32'd0);
        rst_n = 1'b1; force_ack = 1'b1;
        cycle();
        force_ack = 1'b0;
        chk("late_ack_regwr", {31'd0, wbRegWr}, 32'd0);

        // Randomized traffic against the reference model.
        for (int r = 0; r < 600; r++) begin
            instr_t t;
            int kind;
            t = '0;
            kind = $urandom_range(0, 3);
            t.inst = $urandom; t.regwr = 1'($urandom_range(0, 1)); t.jal = ($urandom_range(0, 7) == 0);
            t.loadext = 1'($urandom_range(0, 1)); t.dsize = 2'($urandom_range(0, 3));
            t.fpoint = 2'($urandom_range(0, 3)); t.alu = $urandom; t.busb = $urandom;
            t.rw = 5'($urandom_range(0, 31)); t.ds2 = $urandom;
            t.memwr = (kind == 1); t.memtoreg = (kind == 2);
            cur = t;
            stall_in = ($urandom_range(0, 4) == 0);
            next_delay = $urandom_range(0, 3);
            cycle();
        end
        cur = '0; stall_in = 1'b0;
        for (int k = 0; k < 8; k++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
